// File: rtl/ecd_request_engine.sv
// ecd_request_engine: issues sequentially numbered row requests on an
// AXI-Stream port, keeping at most WINDOW of them unfulfilled, retires them
// on ROW_COMPLETE pulses, then drains and raises a one-cycle DONE_IRQ.
// Control and status live behind a small AXI4-Lite register slave.
//
// Handshake rules: every valid/ready pair transfers exactly when both are
// high at a rising clk edge; a source never drops valid before that edge and
// keeps its payload stable meanwhile. The one payload exception is the
// request held when an abort lands: its TLAST rises so it ends the run.
module ecd_request_engine #(
  parameter int          DATA_W        = 256,
  parameter int          ID_W          = 32,
  parameter int          MAX_WINDOW    = 8,
  parameter logic [31:0] RESET_BASE_ID = 32'h0000_C008
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ROW_COMPLETE,
  input  logic              BUTTON,
  output logic [DATA_W-1:0] AXIS_TX_TDATA,
  output logic              AXIS_TX_TVALID,
  output logic              AXIS_TX_TLAST,
  input  logic              AXIS_TX_TREADY,
  output logic              DONE_IRQ,
  output logic              BUSY,
  output logic [1:0]        state_dbg,
  input  logic [31:0]       S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [31:0]       S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DRAIN, S_DONE} state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t          state_q;
  logic [63:0]     total_q, sent_q, completed_q;
  logic [ID_W-1:0] id_q;
  logic            abort_pend_q;
  logic            done_irq_q;
  logic            st_done_q, st_abort_q, st_spur_q;

  logic [31:0]     count_h_q, count_l_q, window_q, base_id_q;
  logic            bvalid_q, rvalid_q;
  logic [1:0]      bresp_q;
  logic [31:0]     rdata_q;

  logic            busy;
  logic [63:0]     outstanding;
  logic [7:0]      win_eff;
  logic            win_open, tvalid, last_beat, tlast, hs;
  logic            cpl_count;
  logic            wr_fire, rd_fire, wr_err, start_req, abort_req, start_go;
  logic [4:0]      wr_idx, rd_idx;
  logic [63:0]     start_total;
  logic [31:0]     rd_word;

  // Address bits outside the 128-byte word-aligned window alias onto it.
  logic unused_addr;
  assign unused_addr = ^{S_AXI_AWADDR[31:7], S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[31:7], S_AXI_ARADDR[1:0]};

  assign busy        = (state_q != S_IDLE);
  assign outstanding = sent_q - completed_q;
  assign win_open    = (outstanding < {56'd0, win_eff});
  assign tvalid      = (state_q == S_SEND) && win_open;
  assign last_beat   = (sent_q == total_q - 64'd1);
  assign tlast       = tvalid && (last_beat || abort_pend_q);
  assign hs          = tvalid && AXIS_TX_TREADY;
  // A completion only retires something while a run has requests in flight.
  assign cpl_count   = ROW_COMPLETE && outstanding != 64'd0 &&
                       (state_q == S_SEND || state_q == S_DRAIN);

  assign wr_fire     = S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
  assign rd_fire     = S_AXI_ARVALID && !rvalid_q;
  assign wr_idx      = S_AXI_AWADDR[6:2];
  assign rd_idx      = S_AXI_ARADDR[6:2];
  // BUTTON wins over a simultaneous bus start and forces a count of 8.
  assign start_go    = !busy && (BUTTON || start_req);
  assign start_total = BUTTON ? 64'd8 : {count_h_q, count_l_q};

  assign AXIS_TX_TVALID = tvalid;
  assign AXIS_TX_TLAST  = tlast;
  assign DONE_IRQ       = done_irq_q;
  assign BUSY           = busy;
  assign state_dbg      = state_q;
  assign S_AXI_AWREADY  = wr_fire;
  assign S_AXI_WREADY   = wr_fire;
  assign S_AXI_BVALID   = bvalid_q;
  assign S_AXI_BRESP    = bresp_q;
  assign S_AXI_ARREADY  = !rvalid_q;
  assign S_AXI_RVALID   = rvalid_q;
  assign S_AXI_RDATA    = rdata_q;
  assign S_AXI_RRESP    = RESP_OKAY;

  // Request ID in the low bits of TDATA, everything above it zero.
  always_comb begin
    AXIS_TX_TDATA           = '0;
    AXIS_TX_TDATA[ID_W-1:0] = id_q;
  end

  // Effective window: programmed value clamped into 1..MAX_WINDOW.
  always_comb begin
    win_eff = 8'(MAX_WINDOW);
    if (window_q == 32'd0)
      win_eff = 8'd1;
    else if (window_q < 32'(MAX_WINDOW))
      win_eff = window_q[7:0];
  end

  // Decode a bus write into its response and start/abort strobes.
  always_comb begin
    wr_err    = 1'b0;
    start_req = 1'b0;
    abort_req = 1'b0;
    case (wr_idx)
      5'd0, 5'd1, 5'd6, 5'd7: wr_err = busy;
      5'd2:                   wr_err = busy && S_AXI_WDATA[0];
      5'd3, 5'd4, 5'd5:       wr_err = 1'b0;
      default:                wr_err = 1'b1;
    endcase
    if (wr_fire && wr_idx == 5'd2) begin
      start_req = S_AXI_WDATA[0] && !busy;
      abort_req = S_AXI_WDATA[1] && busy;
    end
  end

  // Register read mux; unmapped words read as zero.
  always_comb begin
    rd_word = 32'd0;
    case (rd_idx)
      5'd0: rd_word = count_h_q;
      5'd1: rd_word = count_l_q;
      5'd3: rd_word = {28'd0, st_spur_q, st_abort_q, st_done_q, busy};
      5'd4: rd_word = sent_q[31:0];
      5'd5: rd_word = completed_q[31:0];
      5'd6: rd_word = window_q;
      5'd7: rd_word = base_id_q;
      default: rd_word = 32'd0;
    endcase
  end

  // Configuration registers and the AXI4-Lite response channels.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_h_q <= 32'd0;
      count_l_q <= 32'd32;
      window_q  <= 32'(MAX_WINDOW);
      base_id_q <= RESET_BASE_ID;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      if (wr_fire && !busy) begin
        case (wr_idx)
          5'd0: count_h_q <= S_AXI_WDATA;
          5'd1: count_l_q <= S_AXI_WDATA;
          5'd6: window_q  <= S_AXI_WDATA;
          5'd7: base_id_q <= S_AXI_WDATA;
          default: ;
        endcase
      end
      if (BUTTON && !busy) begin
        count_h_q <= 32'd0;
        count_l_q <= 32'd8;
      end
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_word;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Run sequencing: counters, request ID, sticky status and the done pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      total_q      <= 64'd0;
      sent_q       <= 64'd0;
      completed_q  <= 64'd0;
      id_q         <= '0;
      abort_pend_q <= 1'b0;
      done_irq_q   <= 1'b0;
      st_done_q    <= 1'b0;
      st_abort_q   <= 1'b0;
      st_spur_q    <= 1'b0;
    end else begin
      done_irq_q <= 1'b0;
      if (cpl_count)
        completed_q <= completed_q + 64'd1;
      if (ROW_COMPLETE && !cpl_count)
        st_spur_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start_go) begin
            total_q      <= start_total;
            sent_q       <= 64'd0;
            completed_q  <= 64'd0;
            id_q         <= ID_W'(base_id_q);
            abort_pend_q <= 1'b0;
            st_done_q    <= 1'b0;
            st_abort_q   <= 1'b0;
            st_spur_q    <= 1'b0;
            if (start_total == 64'd0) begin
              state_q    <= S_DONE;
              done_irq_q <= 1'b1;
              st_done_q  <= 1'b1;
            end else begin
              state_q <= S_SEND;
            end
          end
        end
        S_SEND: begin
          if (hs) begin
            sent_q <= sent_q + 64'd1;
            id_q   <= id_q + ID_W'(1);
            if (tlast || abort_req)
              state_q <= S_DRAIN;
            if (abort_req)
              st_abort_q <= 1'b1;
          end else if (abort_req) begin
            st_abort_q <= 1'b1;
            // An offered request must still go out; otherwise stop now.
            if (tvalid)
              abort_pend_q <= 1'b1;
            else
              state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (abort_req || completed_q == sent_q) begin
            if (abort_req)
              st_abort_q <= 1'b1;
            state_q    <= S_DONE;
            done_irq_q <= 1'b1;
            st_done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecd_request_engine.sv
// Bench for ecd_request_engine: bus-driven runs with random ready and
// completion timing; a monitor checks every beat against expected IDs.
module tb_ecd_request_engine;

  localparam int DATA_W = 256;
  localparam int ID_W   = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              row_complete = 1'b0, button = 1'b0, tready = 1'b0;
  logic [DATA_W-1:0] tdata;
  logic              tvalid, tlast, done_irq, busy;
  logic [1:0]        state_dbg;
  logic [31:0]       awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic              awvalid = 1'b0, awready, wvalid = 1'b0, wready;
  logic [1:0]        bresp, rresp;
  logic              bvalid, bready = 1'b1, arvalid = 1'b0, arready, rvalid, rready = 1'b1;

  ecd_request_engine dut (
    .clk(clk), .resetn(resetn), .ROW_COMPLETE(row_complete), .BUTTON(button),
    .AXIS_TX_TDATA(tdata), .AXIS_TX_TVALID(tvalid), .AXIS_TX_TLAST(tlast),
    .AXIS_TX_TREADY(tready), .DONE_IRQ(done_irq), .BUSY(busy), .state_dbg(state_dbg),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready)
  );

  // ---------------- scoreboard state ----------------
  logic [ID_W:0] exp_q[$];   // {tlast, id} for each expected beat
  int            cpl_q[$];   // cycle at which each beat's completion is due
  int  n_cmp = 0, n_err = 0;
  int  beats = 0, cpl_cnt = 0, irq_count = 0, irq_cyc = -1, acc_cyc = 0;
  bit  run_active = 0, cpl_hold = 0, cpl_force = 0;
  int  win_eff = 8, dly_min = 5, dly_max = 5, tready_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    case (tready_mode)
      0:       tready = 1'b1;
      1:       tready = 1'($urandom_range(0, 1));
      default: tready = 1'b0;
    endcase
    row_complete = 1'b0;
    button       = 1'b0;
    if (cpl_force) begin
      row_complete = 1'b1;
      cpl_force    = 0;
      if (cpl_q.size() > 0) void'(cpl_q.pop_front());
    end else if (!cpl_hold && cpl_q.size() > 0 && cpl_q[0] <= cyc) begin
      row_complete = 1'b1;
      void'(cpl_q.pop_front());
    end
  endtask

  task automatic pulse_cpl();
    cpl_force = 1;
    step();
    step();
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int t = 0;
    resp = 2'bxx;
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (awready && wready) break;
      if (++t > 50) begin timeout("aw_accept"); break; end
    end
    step();
    acc_cyc = cyc;
    awvalid = 1'b0; wvalid = 1'b0;
    t = 0;
    forever begin
      @(negedge clk);
      if (bvalid) begin resp = bresp; break; end
      if (++t > 50) begin timeout("b_resp"); break; end
    end
    step();
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
    int t = 0;
    data = 'x;
    araddr = addr; arvalid = 1'b1;
    forever begin
      @(negedge clk);
      if (arready) break;
      if (++t > 50) begin timeout("ar_accept"); break; end
    end
    step();
    arvalid = 1'b0;
    t = 0;
    forever begin
      @(negedge clk);
      if (rvalid) begin data = rdata; check("rresp", rresp, 2'b00); break; end
      if (++t > 50) begin timeout("r_data"); break; end
    end
    step();
  endtask

  task automatic wr_ok(input logic [31:0] addr, input logic [31:0] data);
    logic [1:0] r;
    axi_write(addr, data, r);
    check("wr_resp_okay", r, 2'b00);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    axi_read(addr, d);
    check(name, d, exp);
  endtask

  task automatic set_window(input int v);
    wr_ok(32'h18, 32'(v));
    win_eff = (v < 1) ? 1 : (v > 8 ? 8 : v);
  endtask

  // Reference model: a run of n beats carries base, base+1, ... (mod 2^32),
  // with TLAST on the last one.
  task automatic expect_run(input int n, input logic [31:0] base);
    logic [ID_W:0] e;
    for (int i = 0; i < n; i++) begin
      e[ID_W-1:0] = base + 32'(i);
      e[ID_W]     = (i == n - 1);
      exp_q.push_back(e);
    end
    beats = 0;
    cpl_cnt = 0;
    run_active = 1;
  endtask

  task automatic start_run(input int n, input logic [31:0] base);
    expect_run(n, base);
    wr_ok(32'h08, 32'h1);
  endtask

  task automatic wait_irq(input int maxc);
    int start = irq_count;
    int t = 0;
    while (irq_count == start) begin
      step();
      if (++t > maxc) begin timeout("done_irq"); break; end
    end
  endtask

  // ---------------- monitor ----------------
  logic              prev_v = 1'b0, prev_r = 1'b0;
  logic [DATA_W-1:0] prev_d = '0;
  always @(negedge clk) begin
    if (resetn) begin
      if (prev_v && !prev_r) begin
        check("tvalid_hold", tvalid, 1'b1);
        check("tdata_hold", tdata[63:0], prev_d[63:0]);
      end
      if (tvalid)
        check("window_limit", 64'((beats - cpl_cnt) < win_eff), 64'd1);
      if (done_irq) begin
        irq_count++;
        irq_cyc = cyc;
        run_active = 0;
      end
      if (row_complete && run_active && (beats - cpl_cnt) > 0)
        cpl_cnt++;
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          timeout("unexpected_beat");
        end else begin
          logic [ID_W:0] e;
          e = exp_q.pop_front();
          check("beat_id", tdata[ID_W-1:0], e[ID_W-1:0]);
          check("beat_last", tlast, e[ID_W]);
        end
        check("tdata_upper_zero", 64'(tdata[DATA_W-1:ID_W] == '0), 64'd1);
        beats++;
        cpl_q.push_back(cyc + $urandom_range(dly_min, dly_max));
      end
    end
    prev_v = tvalid && resetn;
    prev_r = tready;
    prev_d = tdata;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int          h, irq0;
    logic [ID_W:0] e;

    repeat (5) step();
    resetn = 1'b1;
    @(negedge clk);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_tdata", tdata[63:0], 0);
    check("rst_irq", done_irq, 0);
    check("rst_busy", busy, 0);
    rd_chk("rst_counth", 32'h00, 32'd0);
    rd_chk("rst_countl", 32'h04, 32'd32);
    rd_chk("rst_ctrl", 32'h08, 32'd0);
    rd_chk("rst_status", 32'h0C, 32'd0);
    rd_chk("rst_sent", 32'h10, 32'd0);
    rd_chk("rst_done", 32'h14, 32'd0);
    rd_chk("rst_window", 32'h18, 32'd8);
    rd_chk("rst_base", 32'h1C, 32'h0000_C008);
    rd_chk("unmapped_read", 32'h20, 32'd0);
    axi_write(32'h24, 32'h5, r);
    check("unmapped_write_slverr", r, 2'b10);

    // Three requests, completions 5 cycles after each.
    wr_ok(32'h04, 32'd3);
    set_window(8);
    irq0 = irq_count;
    start_run(3, 32'h0000_C008);
    wait_irq(200);
    repeat (10) step();
    check("t1_irq_once", irq_count, irq0 + 1);
    check("t1_all_beats", exp_q.size(), 0);
    rd_chk("t1_status", 32'h0C, 32'h2);
    rd_chk("t1_sent", 32'h10, 32'd3);
    rd_chk("t1_done", 32'h14, 32'd3);

    // Window of 2 with completions withheld, released one at a time.
    wr_ok(32'h04, 32'd20);
    set_window(2);
    cpl_hold = 1;
    start_run(20, 32'h0000_C008);
    repeat (20) step();
    @(negedge clk);
    check("t2_stall_beats", beats, 2);
    check("t2_stall_tvalid", tvalid, 0);
    for (int k = 0; k < 18; k++) begin
      pulse_cpl();
      repeat (3) step();
      check("t2_release", beats, (3 + k > 20) ? 20 : 3 + k);
    end
    cpl_hold = 0;
    wait_irq(200);
    rd_chk("t2_sent", 32'h10, 32'd20);

    // Zero-length run: IRQ the cycle after the start is accepted.
    wr_ok(32'h04, 32'd0);
    irq0 = irq_count;
    start_run(0, 32'h0000_C008);
    repeat (5) step();
    check("t3_irq_once", irq_count, irq0 + 1);
    check("t3_irq_latency", irq_cyc, acc_cyc);
    check("t3_no_beats", beats, 0);

    // Abort while a request is held by TREADY=0.
    wr_ok(32'h04, 32'd100);
    set_window(8);
    dly_min = 1; dly_max = 6;
    tready_mode = 1;
    start_run(100, 32'h0000_C008);
    h = 0;
    while (beats < 5 && h < 500) begin step(); h++; end
    tready_mode = 2;
    h = 0;
    forever begin
      step();
      @(negedge clk);
      if (tvalid) break;
      if (++h > 100) begin timeout("t4_hold"); break; end
    end
    h = beats;
    e = exp_q[0];
    e[ID_W] = 1'b1;
    exp_q.delete();
    exp_q.push_back(e);
    wr_ok(32'h08, 32'h2);
    tready_mode = 0;
    wait_irq(500);
    repeat (10) step();
    check("t4_beats", beats, h + 1);
    check("t4_queue_empty", exp_q.size(), 0);
    rd_chk("t4_status", 32'h0C, 32'h6);
    rd_chk("t4_sent", 32'h10, 32'(h + 1));

    // ID wrap from 0xFFFF_FFFE.
    wr_ok(32'h1C, 32'hFFFF_FFFE);
    wr_ok(32'h04, 32'd4);
    tready_mode = 1;
    start_run(4, 32'hFFFF_FFFE);
    wait_irq(300);
    repeat (5) step();
    check("t5_queue_empty", exp_q.size(), 0);
    rd_chk("t5_status", 32'h0C, 32'h2);

    // Spurious completion in idle, cleared by start; writes while busy.
    cpl_q.delete();
    pulse_cpl();
    rd_chk("t6_spurious", 32'h0C, 32'hA);
    wr_ok(32'h04, 32'd10);
    tready_mode = 0;
    cpl_hold = 1;
    start_run(10, 32'hFFFF_FFFE);
    repeat (3) step();
    rd_chk("t6_status_busy", 32'h0C, 32'h1);
    axi_write(32'h08, 32'h1, r);
    check("t6_start_busy", r, 2'b10);
    axi_write(32'h04, 32'd55, r);
    check("t6_countl_busy", r, 2'b10);
    rd_chk("t6_countl_kept", 32'h04, 32'd10);
    cpl_hold = 0;
    wait_irq(300);
    repeat (5) step();
    check("t6_queue_empty", exp_q.size(), 0);

    // BUTTON loads COUNT=8 and starts.
    tready_mode = 1;
    expect_run(8, 32'hFFFF_FFFE);
    button = 1'b1;
    step();
    wait_irq(300);
    repeat (5) step();
    check("t7_queue_empty", exp_q.size(), 0);
    check("t7_beats", beats, 8);
    rd_chk("t7_countl", 32'h04, 32'd8);
    rd_chk("t7_counth", 32'h00, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
